// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arith/address results, plus an
// iterative 32-step multiplier/divider that owns HI/LO and stalls the front end.
module ex_stage #(
  parameter int MULDIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_inst,
  input  logic [2:0]  i_alusel,
  input  logic [4:0]  i_aluop,
  input  logic [31:0] i_srcLeft,
  input  logic [31:0] i_srcRight,
  input  logic [1:0]  i_memop,
  input  logic [4:0]  i_dest,
  input  logic        i_writeEnable,
  input  logic        i_flush,
  output logic [31:0] o_result,
  output logic [1:0]  o_memop,
  output logic [31:0] o_memAddr,
  output logic [31:0] o_storeData,
  output logic [4:0]  o_dest,
  output logic        o_writeEnable,
  output logic        o_overflow,
  output logic        o_stallReq
);
  localparam logic [2:0] SEL_SPECIAL = 3'd0, SEL_LOGIC = 3'd1, SEL_ARITH = 3'd2,
                         SEL_MULDIV  = 3'd3, SEL_MEMACC = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_e;

  md_state_e   state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opb_q, opb_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic        div_zero_q, div_zero_d;

  logic        md_start, stall, kill;
  logic        a_neg, b_neg;
  logic [32:0] mul_sum;
  logic [33:0] div_diff;
  logic [31:0] step_hi, step_lo;
  logic [63:0] prod_fix;
  logic [31:0] mem_addr, add_sum, sub_neg, sub_diff, res;
  logic        add_ovf, sub_ovf, we, ovf;
  logic        unused_bits;

  assign unused_bits = ^{i_inst[31:16], div_diff[32]};
  assign kill        = rst | i_flush;
  assign md_start    = (state_q == S_IDLE) && (i_alusel == SEL_MULDIV) && (i_aluop < 5'd4) && !i_flush;
  assign stall       = !kill && (md_start || state_q == S_BUSY);

  // One iteration: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : 33'd0);
    div_diff = {1'b0, acc_hi_q, acc_lo_q[31]} - {2'b00, opb_q};
    if (is_div_q) begin
      if (!div_diff[33]) begin
        step_hi = div_diff[31:0];
        step_lo = {acc_lo_q[30:0], 1'b1};
      end else begin
        step_hi = {acc_hi_q[30:0], acc_lo_q[31]};
        step_lo = {acc_lo_q[30:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], acc_lo_q[31:1]};
    end
    prod_fix = neg_res_q ? -{step_hi, step_lo} : {step_hi, step_lo};
  end

  assign a_neg = (i_aluop == 5'd0 || i_aluop == 5'd2) && i_srcLeft[31];
  assign b_neg = (i_aluop == 5'd0 || i_aluop == 5'd2) && i_srcRight[31];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opb_d      = opb_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    case (state_q)
      S_IDLE: if (md_start) begin
        acc_hi_d   = '0;
        acc_lo_d   = a_neg ? -i_srcLeft : i_srcLeft;
        opb_d      = b_neg ? -i_srcRight : i_srcRight;
        is_div_d   = i_aluop[1];
        neg_res_d  = a_neg ^ b_neg;
        neg_rem_d  = a_neg;
        div_zero_d = (i_srcRight == '0);
        cnt_d      = '0;
        state_d    = S_BUSY;
      end
      S_BUSY: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == 6'(MULDIV_STEPS - 1)) begin
          if (is_div_q) begin
            hi_d = neg_rem_q ? -step_hi : step_hi;
            lo_d = div_zero_q ? '1 : (neg_res_q ? -step_lo : step_lo);
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!stall && i_alusel == SEL_SPECIAL && i_aluop == 5'd3) hi_d = i_srcLeft;
    if (!stall && i_alusel == SEL_SPECIAL && i_aluop == 5'd4) lo_d = i_srcLeft;
    // A flush abandons any in-flight mul/div without touching HI/LO.
    if (i_flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q    <= S_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opb_q      <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opb_q      <= opb_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign mem_addr = i_srcLeft + {{16{i_inst[15]}}, i_inst[15:0]};
  assign add_sum  = i_srcLeft + i_srcRight;
  assign add_ovf  = (i_srcLeft[31] == i_srcRight[31]) && (add_sum[31] != i_srcLeft[31]);
  assign sub_neg  = -i_srcRight;
  assign sub_diff = i_srcLeft + sub_neg;
  assign sub_ovf  = (i_srcLeft[31] == sub_neg[31]) && (sub_diff[31] != i_srcLeft[31]);

  always_comb begin
    res = '0;
    we  = i_writeEnable;
    ovf = 1'b0;
    case (i_alusel)
      SEL_SPECIAL: case (i_aluop)
        5'd0:    ;
        5'd1:    begin res = hi_q; we = 1'b1; end
        5'd2:    begin res = lo_q; we = 1'b1; end
        default: we = 1'b0;
      endcase
      SEL_LOGIC: case (i_aluop)
        5'd0:    res = i_srcLeft & i_srcRight;
        5'd1:    res = i_srcLeft | i_srcRight;
        5'd2:    res = i_srcLeft ^ i_srcRight;
        5'd3:    res = ~(i_srcLeft | i_srcRight);
        5'd4:    res = i_srcLeft << i_srcRight[4:0];
        5'd5:    res = i_srcLeft >> i_srcRight[4:0];
        5'd6:    res = $signed(i_srcLeft) >>> i_srcRight[4:0];
        default: we = 1'b0;
      endcase
      SEL_ARITH: case (i_aluop)
        5'd0:    begin res = add_sum;  ovf = add_ovf; end
        5'd1:    begin res = sub_diff; ovf = sub_ovf; end
        5'd2:    res = {31'd0, $signed(i_srcLeft) < $signed(i_srcRight)};
        5'd3:    res = {31'd0, i_srcLeft < i_srcRight};
        default: we = 1'b0;
      endcase
      SEL_MEMACC: res = mem_addr;
      default:    we = 1'b0;
    endcase
    if (ovf || stall) we = 1'b0;
  end

  assign o_result      = kill ? '0 : res;
  assign o_memop       = kill ? 2'd0 : i_memop;
  assign o_memAddr     = kill ? '0 : mem_addr;
  assign o_storeData   = kill ? '0 : i_srcRight;
  assign o_dest        = kill ? '0 : i_dest;
  assign o_writeEnable = !kill && we;
  assign o_overflow    = !kill && ovf;
  assign o_stallReq    = stall;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: table-driven single-cycle ops plus
// scoreboarded mul/div, flush and reset sequences.
module tb_ex_stage;
  localparam logic [2:0] SEL_SPECIAL = 3'd0, SEL_LOGIC = 3'd1, SEL_ARITH = 3'd2,
                         SEL_MULDIV  = 3'd3, SEL_MEMACC = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_inst, i_srcLeft, i_srcRight;
  logic [2:0]  i_alusel;
  logic [4:0]  i_aluop, i_dest;
  logic [1:0]  i_memop;
  logic        i_writeEnable, i_flush;
  logic [31:0] o_result, o_memAddr, o_storeData;
  logic [1:0]  o_memop;
  logic [4:0]  o_dest;
  logic        o_writeEnable, o_overflow, o_stallReq;

  ex_stage dut (
    .clk(clk), .rst(rst), .i_inst(i_inst), .i_alusel(i_alusel), .i_aluop(i_aluop),
    .i_srcLeft(i_srcLeft), .i_srcRight(i_srcRight), .i_memop(i_memop), .i_dest(i_dest),
    .i_writeEnable(i_writeEnable), .i_flush(i_flush), .o_result(o_result),
    .o_memop(o_memop), .o_memAddr(o_memAddr), .o_storeData(o_storeData), .o_dest(o_dest),
    .o_writeEnable(o_writeEnable), .o_overflow(o_overflow), .o_stallReq(o_stallReq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        we_in;
    logic [31:0] exp_res;
    logic        exp_we, exp_ovf;
  } vec_t;

  typedef struct packed {
    logic [31:0] hi, lo;
  } hilo_t;

  vec_t  vecs[$];
  vec_t  vec_sb[$];
  hilo_t hilo_sb[$];
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] s, input logic [4:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic wi, input logic [31:0] r,
                              input logic we, input logic ov);
    vec_t v;
    v.sel = s; v.op = o; v.a = a; v.b = b; v.we_in = wi;
    v.exp_res = r; v.exp_we = we; v.exp_ovf = ov;
    return v;
  endfunction

  task automatic set_op(input logic [2:0] s, input logic [4:0] o,
                        input logic [31:0] a, input logic [31:0] b);
    i_alusel = s; i_aluop = o; i_srcLeft = a; i_srcRight = b;
    i_inst = '0; i_memop = 2'd0; i_dest = 5'd9; i_writeEnable = 1'b1; i_flush = 1'b0;
  endtask

  // Drives a mul/div op, measures the stall length and checks the bubble at DONE.
  task automatic run_muldiv(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo, input bit expect_it);
    int n;
    @(posedge clk); #1;
    set_op(SEL_MULDIV, op, a, b);
    if (expect_it) hilo_sb.push_back({ehi, elo});
    n = 0;
    @(negedge clk);
    while (o_stallReq && n < 100) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("stall_cycles op%0d", op), 64'(n), 64'd33);
    check("done_bubble_we", 64'(o_writeEnable), 64'd0);
  endtask

  task automatic check_hilo(input string tag);
    hilo_t e;
    e = hilo_sb.pop_front();
    @(posedge clk); #1;
    set_op(SEL_SPECIAL, 5'd1, 32'h0, 32'h0);
    i_writeEnable = 1'b0;
    @(negedge clk);
    check({tag, "_hi"}, 64'(o_result), 64'(e.hi));
    check({tag, "_mf_we"}, 64'(o_writeEnable), 64'd1);
    @(posedge clk); #1;
    set_op(SEL_SPECIAL, 5'd2, 32'h0, 32'h0);
    @(negedge clk);
    check({tag, "_lo"}, 64'(o_result), 64'(e.lo));
  endtask

  initial begin
    vec_t e;

    vecs.push_back(mk(SEL_SPECIAL, 5'd1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0));
    vecs.push_back(mk(SEL_SPECIAL, 5'd2, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0));
    vecs.push_back(mk(SEL_SPECIAL, 5'd0, 32'h5, 32'h6, 1'b1, 32'h0, 1'b1, 1'b0));
    vecs.push_back(mk(SEL_SPECIAL, 5'd7, 32'h5, 32'h6, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(SEL_ARITH, 5'd0, 32'h7FFFFFFF, 32'h1, 1'b1, 32'h80000000, 1'b0, 1'b1));
    vecs.push_back(mk(SEL_ARITH, 5'd0, 32'h5, 32'h3, 1'b1, 32'h8, 1'b1, 1'b0));
    vecs.push_back(mk(SEL_ARITH, 5'd1, 32'h80000000, 32'h1, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1));
    vecs.push_back(mk(SEL_ARITH, 5'd1, 32'h3, 32'h5, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0));
    vecs.push_back(mk(SEL_ARITH, 5'd0, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(SEL_ARITH, 5'd2, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h1, 1'b1, 1'b0));
    vecs.push_back(mk(SEL_ARITH, 5'd3, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h0, 1'b1, 1'b0));
    vecs.push_back(mk(SEL_ARITH, 5'd5, 32'h1, 32'h1, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(SEL_LOGIC, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hF000F000, 1'b1, 1'b0));
    vecs.push_back(mk(SEL_LOGIC, 5'd1, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hFFF0FFF0, 1'b1, 1'b0));
    vecs.push_back(mk(SEL_LOGIC, 5'd2, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'h0FF00FF0, 1'b1, 1'b0));
    vecs.push_back(mk(SEL_LOGIC, 5'd3, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'h000F000F, 1'b1, 1'b0));
    vecs.push_back(mk(SEL_LOGIC, 5'd4, 32'h1, 32'd31, 1'b1, 32'h80000000, 1'b1, 1'b0));
    vecs.push_back(mk(SEL_LOGIC, 5'd5, 32'h80000000, 32'd31, 1'b1, 32'h1, 1'b1, 1'b0));
    vecs.push_back(mk(SEL_LOGIC, 5'd6, 32'h80000000, 32'd4, 1'b1, 32'hF8000000, 1'b1, 1'b0));
    vecs.push_back(mk(SEL_LOGIC, 5'd4, 32'h12345678, 32'h20, 1'b1, 32'h12345678, 1'b1, 1'b0));
    vecs.push_back(mk(SEL_LOGIC, 5'd6, 32'h87654321, 32'h0, 1'b1, 32'h87654321, 1'b1, 1'b0));
    vecs.push_back(mk(SEL_LOGIC, 5'd7, 32'h1, 32'h1, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(3'd6, 5'd0, 32'h1, 32'h1, 1'b1, 32'h0, 1'b0, 1'b0));

    // Reset: outputs forced to zero regardless of inputs.
    rst = 1'b1;
    set_op(SEL_ARITH, 5'd0, 32'h5, 32'h3);
    i_memop = 2'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_result", 64'(o_result), 64'd0);
    check("rst_memop", 64'(o_memop), 64'd0);
    check("rst_we", 64'(o_writeEnable), 64'd0);
    check("rst_storedata", 64'(o_storeData), 64'd0);
    check("rst_stall", 64'(o_stallReq), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      set_op(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b);
      i_writeEnable = vecs[i].we_in;
      vec_sb.push_back(vecs[i]);
      @(negedge clk);
      e = vec_sb.pop_front();
      check($sformatf("vec%0d_result", i), 64'(o_result), 64'(e.exp_res));
      check($sformatf("vec%0d_we", i), 64'(o_writeEnable), 64'(e.exp_we));
      check($sformatf("vec%0d_ovf", i), 64'(o_overflow), 64'(e.exp_ovf));
    end

    // Address generation and pass-through.
    @(posedge clk); #1;
    set_op(SEL_MEMACC, 5'd0, 32'h1000, 32'hAB);
    i_inst = 32'h1234FFFC; i_memop = 2'd2;
    @(negedge clk);
    check("mem_addr", 64'(o_memAddr), 64'h0FFC);
    check("mem_result", 64'(o_result), 64'h0FFC);
    check("mem_storedata", 64'(o_storeData), 64'hAB);
    check("mem_memop", 64'(o_memop), 64'd2);
    check("mem_dest", 64'(o_dest), 64'd9);

    // MTHI/MTLO
    @(posedge clk); #1;
    set_op(SEL_SPECIAL, 5'd3, 32'h11111111, 32'h0);
    @(negedge clk);
    check("mthi_we", 64'(o_writeEnable), 64'd0);
    @(posedge clk); #1;
    set_op(SEL_SPECIAL, 5'd4, 32'h22222222, 32'h0);
    hilo_sb.push_back({32'h11111111, 32'h22222222});
    check_hilo("mthilo");

    // Back-to-back: second op starts straight out of DONE.
    run_muldiv(5'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_muldiv(5'd0, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1);
    check_hilo("mult");
    run_muldiv(5'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
    check_hilo("multu");
    run_muldiv(5'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
    check_hilo("div");
    run_muldiv(5'd3, 32'h7, 32'h0, 32'h7, 32'hFFFFFFFF, 1'b1);
    check_hilo("divu0");

    // Flush at BUSY step 10: stall drops at once, HI/LO untouched.
    @(posedge clk); #1;
    set_op(SEL_MULDIV, 5'd3, 32'd100, 32'd7);
    repeat (11) @(posedge clk);
    #1;
    i_flush = 1'b1; i_memop = 2'd2;
    @(negedge clk);
    check("flush_stall", 64'(o_stallReq), 64'd0);
    check("flush_memop", 64'(o_memop), 64'd0);
    check("flush_we", 64'(o_writeEnable), 64'd0);
    @(posedge clk); #1;
    set_op(SEL_SPECIAL, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    check("post_flush_stall", 64'(o_stallReq), 64'd0);
    hilo_sb.push_back({32'h7, 32'hFFFFFFFF});
    check_hilo("flush");

    // Reset at BUSY step 10: HI/LO cleared, FSM back in IDLE.
    @(posedge clk); #1;
    set_op(SEL_MULDIV, 5'd3, 32'd100, 32'd7);
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_stall", 64'(o_stallReq), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_op(SEL_SPECIAL, 5'd0, 32'h0, 32'h0);
    hilo_sb.push_back({32'h0, 32'h0});
    check_hilo("midrst");
    run_muldiv(5'd0, 32'd3, 32'd4, 32'h0, 32'd12, 1'b1);
    check_hilo("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage; sits directly downstream of the ID/EX pipeline register and feeds the EX/MEM register.
- Computes single-cycle logic, shift and arithmetic results, and memory addresses.
- Runs an iterative 32-step multiplier/divider that owns the HI/LO registers and stalls the front end while busy.
- Also handles MFHI/MFLO/MTHI/MTLO against HI/LO.

Parameters:
- MULDIV_STEPS, 32, number of iteration cycles for multiply and divide; fixed at 32 for a 32-bit datapath.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_inst  in  32  instruction word; only [15:0] is used, as the memory offset
- i_alusel  in  3  op class: 0 SPECIAL, 1 LOGIC, 2 ARITH, 3 MULDIV, 4 MEMACC
- i_aluop  in  5  op within class (encodings in Behaviour)
- i_srcLeft  in  32  operand A
- i_srcRight  in  32  operand B; store data for MEMACC
- i_memop  in  2  memory op from ID/EX, passed through
- i_dest  in  5  destination register
- i_writeEnable  in  1  register write request from ID/EX
- i_flush  in  1  kill the current instruction and abort any mul/div
- o_result  out  32  register write data
- o_memop  out  2  memory op to EX/MEM
- o_memAddr  out  32  srcLeft + sign-extended inst[15:0]
- o_storeData  out  32  equals i_srcRight
- o_dest  out  5  destination register
- o_writeEnable  out  1  final register write enable
- o_overflow  out  1  signed overflow on ADD/SUB
- o_stallReq  out  1  hold IF/ID/ID-EX; EX/MEM inserts a bubble

Behaviour:
- Outputs are combinational from the inputs, the FSM state and HI/LO.
- While rst or i_flush is high, all outputs are 0 except o_memop = NOP (0).
- Op encodings:
  - SPECIAL: 0 NOP, 1 MFHI, 2 MFLO, 3 MTHI, 4 MTLO
  - LOGIC: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 SLL, 5 SRL, 6 SRA; shift amount is srcRight[4:0], value shifted is srcLeft
  - ARITH: 0 ADD, 1 SUB, 2 SLT (signed), 3 SLTU
  - MULDIV: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
  - MEMACC: any aluop; o_result = o_memAddr
- Unlisted op codes give o_result = 0 and o_writeEnable = 0.
- o_writeEnable:
  - equals i_writeEnable by default;
  - forced to 1 for MFHI/MFLO;
  - forced to 0 for MULDIV, MTHI/MTLO, ADD/SUB with overflow, and while o_stallReq = 1.
- Overflow is detected as: operand signs equal, and result sign differs from them. For SUB, the comparison uses the negated srcRight.
- MTHI/MTLO write HI/LO from srcLeft at the clock edge, when not stalled and not flushed.
- MFHI/MFLO read the current HI/LO.
- HI/LO reset to 0.
- Mul/div FSM states are IDLE, BUSY, DONE. Reset and flush both force IDLE.
- IDLE, MULDIV present:
  - latch operand magnitudes (signed ops take absolute values);
  - record the result signs;
  - clear the 6-bit step counter;
  - go to BUSY;
  - o_stallReq = 1 in this cycle.
- BUSY: one shift-add step (multiply) or one restoring subtract step (divide) per cycle; o_stallReq = 1.
- Counter reaches MULDIV_STEPS-1:
  - apply the sign fix: product negated if the signs differ; quotient sign is the XOR of operand signs; remainder takes the dividend's sign;
  - write HI/LO: product {HI,LO}, or HI = remainder and LO = quotient;
  - go to DONE.
- DONE:
  - o_stallReq = 0, so the op retires as a bubble;
  - go to IDLE unconditionally, so the same op is never restarted.
- Divide by zero: no exception; HI = dividend, LO = 0xFFFFFFFF. It still takes the full latency.
- Total stall: 33 cycles (IDLE cycle + 32 BUSY cycles); DONE is the 34th cycle.
- A MULDIV immediately after DONE starts normally in IDLE.
- i_flush in BUSY returns to IDLE with HI/LO unchanged.
- rst mid-operation clears the FSM and HI/LO.
- SLT/SLTU give 0 or 1; shifts by 0 pass srcLeft unchanged.

Test Plan:
- ADD 0x7FFFFFFF + 1, i_writeEnable = 1 -> o_overflow = 1, o_writeEnable = 0. ADD 5 + 3 -> o_result = 8, o_writeEnable = 1.
- SRA srcLeft = 0x80000000, srcRight = 4 -> 0xF8000000. SLT -1 vs 1 -> 1. SLTU -1 vs 1 -> 0.
- MULT 0xFFFFFFFE (-2) x 3 -> o_stallReq high exactly 33 cycles; HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. The following MFLO returns 0xFFFFFFFA with o_writeEnable = 1.
- DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7 / 0 -> HI = 7, LO = 0xFFFFFFFF.
- MEMACC srcLeft = 0x1000, inst[15:0] = 0xFFFC, srcRight = 0xAB -> o_memAddr = 0x0FFC, o_storeData = 0xAB, o_memop passed through.
- DIVU starts, i_flush at BUSY step 10 -> stall drops the same cycle, HI/LO keep prior values. Repeat with rst -> HI = LO = 0, FSM IDLE.
